// File: rtl/defs_pkg.sv
// Shared types for the CPU control path: control bundle, ALU flags, opcodes, FSM states.
// CU_HALT_EN adds the S_HALT state used by the HALT opcode.
package defs_pkg;

   typedef struct packed {
      logic z;
      logic n;
      logic c;
      logic v;
   } alu_flags_t;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4
   } alu_op_e;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_LDI  = 4'h6,
      OP_LD   = 4'h7,
      OP_ST   = 4'h8,
      OP_BEQ  = 4'h9,
      OP_BNE  = 4'hA,
      OP_BLT  = 4'hB,
      OP_JMP  = 4'hC,
      OP_JR   = 4'hD,
      OP_CMP  = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef struct packed {
      logic       PC_write;
      logic       PC_sel;
      logic [1:0] ADDER_sel;
      logic       IR_load;
      logic       AB_load;
      logic       REG2_sel;
      logic       RF_write;
      logic [1:0] REGW_sel;
      logic [2:0] ALU_op;
      logic       ACC_load;
      logic       FLAGS_load;
      logic       MAR_load;
      logic       MDR_load;
      logic       MEM_write;
   } ctrl_sig_t;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_IR     = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_STORE  = 3'd5,
`ifdef CU_HALT_EN
      S_WB     = 3'd6,
      S_HALT   = 3'd7
`else
      S_WB     = 3'd6
`endif
   } cu_state_e;

   localparam logic [1:0] ADDER_PLUS2 = 2'd0;
   localparam logic [1:0] ADDER_IMM8  = 2'd1;
   localparam logic [1:0] ADDER_IMM12 = 2'd2;

   localparam logic [1:0] REGW_ACC  = 2'd0;
   localparam logic [1:0] REGW_MDR  = 2'd1;
   localparam logic [1:0] REGW_IMM4 = 2'd2;

   function automatic alu_op_e alu_op_for(input opcode_e op);
      alu_op_e r;
      r = ALU_ADD;
      case (op)
         OP_SUB, OP_CMP: r = ALU_SUB;
         OP_AND:         r = ALU_AND;
         OP_OR:          r = ALU_OR;
         OP_XOR:         r = ALU_XOR;
         default:        r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator: BEQ on Z, BNE on !Z, BLT on N^V; zero for any other opcode.
module branch_cond
   import defs_pkg::*;
(
   input  opcode_e    opcode,
   input  alu_flags_t flags,
   output logic       take
);

   logic unused_carry;
   assign unused_carry = flags.c;

   always_comb begin
      take = 1'b0;
      case (opcode)
         OP_BEQ:  take = flags.z;
         OP_BNE:  take = ~flags.z;
         OP_BLT:  take = flags.n ^ flags.v;
         default: take = 1'b0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM: Moore decode of state plus opcode into the datapath control bundle.
// CU_HALT_EN enables the HALT opcode (S_HALT, halted output); otherwise opcode F behaves as NOP.
module control_unit
   import defs_pkg::*;
#(
   parameter int        INSTR_WIDTH = 16,
   parameter cu_state_e RESET_STATE = S_FETCH
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [INSTR_WIDTH-1:0] instruct,
   input  alu_flags_t             flags,
   output ctrl_sig_t              sigs,
   output logic                   halted
);

   cu_state_e state_q, state_d;
   logic      take_q, take_d;
   logic      take;
   opcode_e   op;

   assign op = opcode_e'(instruct[3:0]);

   logic unused_instr;
   assign unused_instr = ^instruct[INSTR_WIDTH-1:4];

   branch_cond u_branch_cond (
      .opcode (op),
      .flags  (flags),
      .take   (take)
   );

   // Condition is latched at the end of S_DECODE so S_EXEC drives PC_write from a flop;
   // flags are registered and unchanged between the two cycles.
   always_comb begin
      take_d = take_q;
      if (state_q == S_DECODE) take_d = take;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RESET_STATE;
         take_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         take_q  <= take_d;
      end
   end

   always_comb begin
      sigs    = '0;
      state_d = state_q;
      case (state_q)
         S_FETCH: state_d = S_IR;
         S_IR: begin
            sigs.IR_load   = 1'b1;
            sigs.PC_write  = 1'b1;
            sigs.ADDER_sel = ADDER_PLUS2;
            state_d        = S_DECODE;
         end
         S_DECODE: begin
            sigs.AB_load  = 1'b1;
            sigs.REG2_sel = 1'b0;
            case (op)
               OP_NOP: state_d = S_FETCH;
               OP_LDI: state_d = S_WB;
               OP_JR: begin
                  sigs.PC_write = 1'b1;
                  sigs.PC_sel   = 1'b1;
                  state_d       = S_FETCH;
               end
`ifdef CU_HALT_EN
               OP_HALT: state_d = S_HALT;
`else
               OP_HALT: state_d = S_FETCH;
`endif
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            state_d = S_FETCH;
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  sigs.ALU_op     = alu_op_for(op);
                  sigs.ACC_load   = 1'b1;
                  sigs.FLAGS_load = 1'b1;
                  state_d         = S_WB;
               end
               OP_CMP: begin
                  sigs.ALU_op     = ALU_SUB;
                  sigs.FLAGS_load = 1'b1;
               end
               OP_BEQ, OP_BNE, OP_BLT: begin
                  sigs.PC_write  = take_q;
                  sigs.ADDER_sel = ADDER_IMM8;
               end
               OP_JMP: begin
                  sigs.PC_write  = 1'b1;
                  sigs.ADDER_sel = ADDER_IMM12;
               end
               OP_LD, OP_ST: begin
                  sigs.MAR_load = 1'b1;
                  state_d       = S_MEM;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (op == OP_ST) begin
               sigs.AB_load  = 1'b1;
               sigs.REG2_sel = 1'b1;
               state_d       = S_STORE;
            end else begin
               sigs.MDR_load = 1'b1;
               state_d       = S_WB;
            end
         end
         S_STORE: begin
            sigs.MEM_write = 1'b1;
            state_d        = S_FETCH;
         end
         S_WB: begin
            sigs.RF_write = 1'b1;
            case (op)
               OP_LD:   sigs.REGW_sel = REGW_MDR;
               OP_LDI:  sigs.REGW_sel = REGW_IMM4;
               default: sigs.REGW_sel = REGW_ACC;
            endcase
            state_d = S_FETCH;
         end
`ifdef CU_HALT_EN
         S_HALT: state_d = S_HALT;
`endif
         default: state_d = S_FETCH;
      endcase
   end

`ifdef CU_HALT_EN
   assign halted = (state_q == S_HALT);
`else
   assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction-level reference model fills a per-cycle expected queue,
// a negedge monitor compares {halted, sigs}; ends with a reset-abort check during LD write-back.
module tb_control_unit;
   import defs_pkg::*;

   logic       clk = 1'b0;
   logic       resetn;
   logic [15:0] instruct;
   alu_flags_t flags;
   ctrl_sig_t  sigs;
   logic       halted;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;
   int cyc = 0;

   logic [18:0] exp_q[$];
   logic [15:0] prog_q[$];
   logic [3:0]  flg_q[$];

   always #5 clk = ~clk;

   control_unit dut (
      .clk      (clk),
      .resetn   (resetn),
      .instruct (instruct),
      .flags    (flags),
      .sigs     (sigs),
      .halted   (halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic h, input ctrl_sig_t s);
      exp_q.push_back({h, s});
   endtask

   // One instruction expands into its list of per-cycle control words.
   task automatic model(input logic [15:0] ir, input alu_flags_t f);
      ctrl_sig_t  s;
      logic [3:0] op;
      logic       tk;
      op = ir[3:0];
      s = '0; push(1'b0, s);
      s = '0; s.IR_load = 1'b1; s.PC_write = 1'b1; push(1'b0, s);
      s = '0; s.AB_load = 1'b1;
      if (op == 4'hD) begin s.PC_write = 1'b1; s.PC_sel = 1'b1; end
      push(1'b0, s);
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            s = '0; s.ALU_op = 3'(op - 4'd1); s.ACC_load = 1'b1; s.FLAGS_load = 1'b1; push(1'b0, s);
            s = '0; s.RF_write = 1'b1; s.REGW_sel = 2'd0; push(1'b0, s);
         end
         4'h6: begin
            s = '0; s.RF_write = 1'b1; s.REGW_sel = 2'd2; push(1'b0, s);
         end
         4'h7: begin
            s = '0; s.MAR_load = 1'b1; push(1'b0, s);
            s = '0; s.MDR_load = 1'b1; push(1'b0, s);
            s = '0; s.RF_write = 1'b1; s.REGW_sel = 2'd1; push(1'b0, s);
         end
         4'h8: begin
            s = '0; s.MAR_load = 1'b1; push(1'b0, s);
            s = '0; s.AB_load = 1'b1; s.REG2_sel = 1'b1; push(1'b0, s);
            s = '0; s.MEM_write = 1'b1; push(1'b0, s);
         end
         4'h9, 4'hA, 4'hB: begin
            if (op == 4'h9)      tk = f.z;
            else if (op == 4'hA) tk = ~f.z;
            else                 tk = f.n ^ f.v;
            s = '0; s.PC_write = tk; s.ADDER_sel = 2'd1; push(1'b0, s);
         end
         4'hC: begin
            s = '0; s.PC_write = 1'b1; s.ADDER_sel = 2'd2; push(1'b0, s);
         end
         4'hE: begin
            s = '0; s.ALU_op = 3'd1; s.FLAGS_load = 1'b1; push(1'b0, s);
         end
         4'hF: begin
`ifdef CU_HALT_EN
            for (int k = 0; k < 100; k++) push(1'b1, '0);
`endif
         end
         default: ;
      endcase
   endtask

   task automatic add_instr(input logic [15:0] ir, input logic [3:0] f);
      prog_q.push_back(ir);
      flg_q.push_back(f);
      model(ir, alu_flags_t'(f));
   endtask

   always @(negedge clk) begin
      logic [18:0] e;
      cyc++;
      if (mon_en && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("cycle_sigs", {13'd0, halted, sigs}, {13'd0, e});
      end
   end

   initial begin
      int n;
      logic [11:0] hi;
      logic [3:0]  op;
      resetn   = 1'b0;
      instruct = 16'h0000;
      flags    = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_sigs", sigs, 0);
      check("reset_halted", {31'd0, halted}, 0);

      add_instr(16'h0000, 4'h0);
      add_instr(16'h0000, 4'h0);
      add_instr(16'h3121, 4'h0);
      add_instr(16'hFC09, 4'b1000);
      add_instr(16'hFC09, 4'b0000);
      add_instr(16'h0038, 4'h0);
      add_instr(16'h0047, 4'h0);
      add_instr(16'h5A06, 4'h0);
      add_instr(16'h000D, 4'h0);
      add_instr(16'h123C, 4'h0);
      add_instr(16'h000E, 4'h0);
      add_instr(16'h100A, 4'b0000);
      add_instr(16'h100A, 4'b1000);
      add_instr(16'h200B, 4'b0100);
      add_instr(16'h200B, 4'b0101);
      add_instr(16'h200B, 4'b0001);
      for (int i = 0; i < 50; i++) begin
         hi = 12'($urandom_range(0, 4095));
         op = 4'($urandom_range(0, 14));
         add_instr({hi, op}, 4'($urandom_range(0, 15)));
      end
      add_instr(16'h000F, 4'h0);

      @(posedge clk);
      #1;
      resetn = 1'b1;
      mon_en = 1'b1;

      foreach (prog_q[i]) begin
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!sigs.IR_load && n < 50);
         if (!sigs.IR_load) begin
            check("ir_load_timeout", 0, 1);
            break;
         end
         @(posedge clk);
         #1;
         instruct = prog_q[i];
         flags    = alu_flags_t'(flg_q[i]);
      end

      n = 0;
      while (exp_q.size() > 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      check("queue_drained", exp_q.size(), 0);
      mon_en = 1'b0;

      // LD interrupted by reset during its write-back cycle.
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      instruct = 16'h0047;
      flags    = '0;
      resetn   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!sigs.RF_write && n < 20);
      check("ld_wb_cycle", n, 6);
      check("ld_wb_regw", {30'd0, sigs.REGW_sel}, 1);
      resetn = 1'b0;
      #1;
      check("abort_rf_write", {31'd0, sigs.RF_write}, 0);
      check("abort_sigs", sigs, 0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      @(negedge clk);
      check("restart_fetch", sigs, 0);
      @(negedge clk);
      check("restart_ir_load", {31'd0, sigs.IR_load}, 1);
      check("restart_pc_write", {31'd0, sigs.PC_write}, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
